// File: rtl/dt_pkg.sv
// Shared types and node-entry layout helpers for the decision-tree walker.
// Node entry, MSB to LSB: {is_leaf, feat_idx, cls, left, right}.
package dt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Field widths never collapse to zero, even for degenerate parameters.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int fidx_w(input int n_feat);
      return clog2_min1(n_feat);
   endfunction

   function automatic int off_right(input int aw);
      return 0;
   endfunction

   function automatic int off_left(input int aw);
      return aw;
   endfunction

   function automatic int off_cls(input int aw);
      return 2 * aw;
   endfunction

   function automatic int off_fidx(input int class_w, input int aw);
      return 2 * aw + class_w;
   endfunction

   function automatic int off_leaf(input int n_feat, input int class_w, input int aw);
      return 2 * aw + class_w + fidx_w(n_feat);
   endfunction

   function automatic int node_w(input int n_feat, input int class_w, input int aw);
      return 1 + fidx_w(n_feat) + class_w + 2 * aw;
   endfunction

endpackage

// File: rtl/dt_tree_walker_if.sv
// Feature-vector request and classification response handshakes of the walker.
interface dt_tree_walker_if #(
   parameter int N_FEAT  = 10,
   parameter int CLASS_W = 3
);
   logic               in_valid;
   logic               in_ready;
   logic [N_FEAT-1:0]  in_feat;
   logic               out_valid;
   logic               out_ready;
   logic [CLASS_W-1:0] out_class;
   logic               out_err;

   modport master (
      output in_valid, in_feat, out_ready,
      input  in_ready, out_valid, out_class, out_err
   );

   modport slave (
      input  in_valid, in_feat, out_ready,
      output in_ready, out_valid, out_class, out_err
   );
endinterface

// File: rtl/dt_node_table.sv
// Node table: plain register array, one write port, combinational read by pointer.
// Contents are intentionally not reset so a walker reset keeps the loaded tree.
module dt_node_table #(
   parameter int NODE_W    = 18,
   parameter int MAX_NODES = 32,
   parameter int AW        = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [NODE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [NODE_W-1:0] rdata
);
   logic [NODE_W-1:0] node_reg [MAX_NODES];

   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < 32'(MAX_NODES)))
         node_reg[waddr] <= wdata;
   end

   assign rdata = (32'(raddr) < 32'(MAX_NODES)) ? node_reg[raddr] : '0;
endmodule

// File: rtl/dt_tree_walker.sv
// Binary decision-tree walker: visits one node per cycle from node 0 to a leaf.
// Optional result counters stat_cnt/stat_err are built when DT_WALK_STATS_EN is defined.
module dt_tree_walker
   import dt_pkg::*;
#(
   parameter int  N_FEAT    = 10,
   parameter int  CLASS_W   = 3,
   parameter int  MAX_NODES = 32,
   parameter int  MAX_DEPTH = 8,
   localparam int AW        = $clog2(MAX_NODES),
   localparam int NODE_W    = node_w(N_FEAT, CLASS_W, AW)
) (
   input  logic              clk,
   input  logic              rst_n,
   dt_tree_walker_if.slave   io,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [NODE_W-1:0] cfg_data,
   output logic              cfg_busy
`ifdef DT_WALK_STATS_EN
   ,
   output logic [15:0]       stat_cnt,
   output logic [15:0]       stat_err
`endif
);
   localparam int FW        = fidx_w(N_FEAT);
   localparam int DW        = clog2_min1(MAX_DEPTH);
   localparam int OFF_R     = off_right(AW);
   localparam int OFF_L     = off_left(AW);
   localparam int OFF_CLS   = off_cls(AW);
   localparam int OFF_FIDX  = off_fidx(CLASS_W, AW);
   localparam int OFF_LEAF  = off_leaf(N_FEAT, CLASS_W, AW);

   state_t             state_reg, state_next;
   logic [N_FEAT-1:0]  feat_reg;
   logic [AW-1:0]      ptr_reg;
   logic [DW-1:0]      depth_reg;
   logic [CLASS_W-1:0] class_reg;
   logic               err_reg;

   logic [NODE_W-1:0]  node;
   logic               nd_leaf;
   logic [FW-1:0]      nd_fidx;
   logic [CLASS_W-1:0] nd_cls;
   logic [AW-1:0]      nd_left, nd_right;
   logic               feat_bit;
   logic [AW-1:0]      child;
   logic               walk_err;
   logic               tbl_we;

   assign tbl_we = cfg_we && !cfg_busy;

   dt_node_table #(
      .NODE_W    (NODE_W),
      .MAX_NODES (MAX_NODES),
      .AW        (AW)
   ) u_table (
      .clk   (clk),
      .we    (tbl_we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (ptr_reg),
      .rdata (node)
   );

   assign nd_leaf  = node[OFF_LEAF];
   assign nd_fidx  = node[OFF_FIDX +: FW];
   assign nd_cls   = node[OFF_CLS +: CLASS_W];
   assign nd_left  = node[OFF_L +: AW];
   assign nd_right = node[OFF_R +: AW];

   // An out-of-range feature index selects 0 here, but it is flagged as an error anyway.
   always_comb begin
      feat_bit = 1'b0;
      for (int i = 0; i < N_FEAT; i++)
         if (32'(nd_fidx) == 32'(i))
            feat_bit = feat_reg[i];
      child    = feat_bit ? nd_right : nd_left;
      walk_err = !nd_leaf &&
                 ((32'(nd_fidx) >= 32'(N_FEAT)) ||
                  (32'(child) >= 32'(MAX_NODES)) ||
                  (32'(depth_reg) == 32'(MAX_DEPTH - 1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (io.in_valid)         state_next = ST_WALK;
         ST_WALK: if (nd_leaf || walk_err) state_next = ST_DONE;
         ST_DONE: if (io.out_ready)        state_next = ST_IDLE;
         default:                          state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      io.in_ready  = (state_reg == ST_IDLE);
      io.out_valid = (state_reg == ST_DONE);
      cfg_busy     = (state_reg != ST_IDLE);
   end

   assign io.out_class = class_reg;
   assign io.out_err   = err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_reg  <= '0;
         ptr_reg   <= '0;
         depth_reg <= '0;
         class_reg <= '0;
         err_reg   <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
         if (io.in_valid) begin
            feat_reg  <= io.in_feat;
            ptr_reg   <= '0;
            depth_reg <= '0;
         end
      end else if (state_reg == ST_WALK) begin
         if (nd_leaf) begin
            class_reg <= nd_cls;
            err_reg   <= 1'b0;
         end else if (walk_err) begin
            class_reg <= '0;
            err_reg   <= 1'b1;
         end else begin
            ptr_reg   <= child;
            depth_reg <= depth_reg + DW'(1);
         end
      end
   end

`ifdef DT_WALK_STATS_EN
   logic [15:0] stat_cnt_reg, stat_err_reg;
   logic        consume;

   assign consume = io.out_valid && io.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt_reg <= '0;
         stat_err_reg <= '0;
      end else if (consume) begin
         if (stat_cnt_reg != 16'hFFFF)
            stat_cnt_reg <= stat_cnt_reg + 16'd1;
         if (err_reg && (stat_err_reg != 16'hFFFF))
            stat_err_reg <= stat_err_reg + 16'd1;
      end
   end

   assign stat_cnt = stat_cnt_reg;
   assign stat_err = stat_err_reg;
`endif
endmodule

// File: tb/tb_dt_tree_walker.sv
// Randomized scoreboard bench for dt_tree_walker with a tree-walking reference model.
// Also checks the result counters when DT_WALK_STATS_EN is defined.
module tb_dt_tree_walker;
   localparam int NF = 10;
   localparam int CW = 3;
   localparam int MN = 24;
   localparam int MD = 8;
   localparam int AW = 5;
   localparam int NW = 1 + 4 + CW + 2 * AW;

   typedef struct {
      logic [CW-1:0] cls;
      logic          err;
      int            lat;
      int            acc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           cfg_we = 1'b0;
   logic [AW-1:0]  cfg_addr = '0;
   logic [NW-1:0]  cfg_data = '0;
   logic           cfg_busy;
`ifdef DT_WALK_STATS_EN
   logic [15:0]    stat_cnt, stat_err;
`endif

   dt_tree_walker_if #(.N_FEAT(NF), .CLASS_W(CW)) io ();

   dt_tree_walker #(
      .N_FEAT(NF), .CLASS_W(CW), .MAX_NODES(MN), .MAX_DEPTH(MD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io       (io),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_busy (cfg_busy)
`ifdef DT_WALK_STATS_EN
      ,
      .stat_cnt (stat_cnt),
      .stat_err (stat_err)
`endif
   );

   always #5 clk = ~clk;

   exp_t          sb[$];
   exp_t          cur;
   logic [NW-1:0] mdl [MN];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            consumed = 0;
   int            err_consumed = 0;
   bit            seen = 0;
   bit            bp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      if (rst_n && io.out_valid && io.out_ready) begin
         consumed++;
         if (io.out_err) err_consumed++;
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NW-1:0] mk(input logic leaf, input logic [3:0] fi,
                                        input logic [CW-1:0] cls,
                                        input logic [AW-1:0] l, input logic [AW-1:0] r);
      return {leaf, fi, cls, l, r};
   endfunction

   // Reference walk over the model table, straight from the tree rules.
   function automatic void ref_walk(input logic [NF-1:0] f, output logic [CW-1:0] c,
                                    output logic e, output int lat);
      int p = 0;
      c = '0; e = 1'b0; lat = 0;
      for (int step = 0; step < MD; step++) begin
         logic [NW-1:0] n = mdl[p];
         int fi  = int'(n[16:13]);
         int nxt;
         lat = step + 1;
         if (n[17]) begin
            c = n[12:10];
            return;
         end
         if (fi >= NF || step == MD - 1) begin
            e = 1'b1;
            return;
         end
         nxt = f[fi] ? int'(n[4:0]) : int'(n[9:5]);
         if (nxt >= MN) begin
            e = 1'b1;
            return;
         end
         p = nxt;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) seen = 0;
      else if (io.out_valid) begin
         if (!seen) begin
            seen = 1;
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result got class %0d err %0d expected none",
                        io.out_class, io.out_err);
            end else begin
               cur = sb.pop_front();
               chk("class", 32'(io.out_class), 32'(cur.cls));
               chk("err", 32'(io.out_err), 32'(cur.err));
               chk("latency", cyc - cur.acc, cur.lat);
            end
         end else begin
            chk("hold_class", 32'(io.out_class), 32'(cur.cls));
            chk("hold_err", 32'(io.out_err), 32'(cur.err));
         end
         chk("in_ready_done", 32'(io.in_ready), 0);
         chk("cfg_busy_done", 32'(cfg_busy), 1);
      end else seen = 0;
   end

   task automatic tick();
      @(posedge clk); #1;
      if (bp) io.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic cfg_write(input int a, input logic [NW-1:0] d);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
      if (!cfg_busy && a < MN) mdl[a] = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [NF-1:0] f, input bit wr, input int wa, input logic [NW-1:0] wd);
      exp_t e;
      int   n = 0;
      while (!io.in_ready && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL send_timeout got busy expected in_ready");
      end
      io.in_valid = 1'b1; io.in_feat = f;
      if (wr) begin
         cfg_we = 1'b1; cfg_addr = AW'(wa); cfg_data = wd;
         if (wa < MN) mdl[wa] = wd;
      end
      ref_walk(f, e.cls, e.err, e.lat);
      e.acc = cyc + 1;
      sb.push_back(e);
      $display("send feat=%03h exp_class=%0d exp_err=%0d exp_lat=%0d", f, e.cls, e.err, e.lat);
      @(posedge clk); #1;
      io.in_valid = 1'b0; cfg_we = 1'b0;
      io.in_feat = NF'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || !io.in_ready) && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL result_timeout got pending %0d expected 0", sb.size());
      end
   endtask

   task automatic load_chain(input bit last_leaf);
      for (int i = 0; i < MD - 1; i++)
         cfg_write(i, mk(1'b0, 4'(i), 3'd0, AW'(i + 1), AW'(i + 1)));
      cfg_write(MD - 1, mk(last_leaf, 4'd0, 3'd4, 5'd0, 5'd0));
   endtask

   initial begin
      io.in_valid = 1'b0; io.in_feat = '0; io.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(io.in_ready), 1);
      chk("rst_out_valid", 32'(io.out_valid), 0);
      chk("rst_out_class", 32'(io.out_class), 0);
      chk("rst_out_err", 32'(io.out_err), 0);
      chk("rst_cfg_busy", 32'(cfg_busy), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cfg_write(0, mk(1'b1, 4'd0, 3'd5, 5'd0, 5'd0));
      send(NF'($urandom), 0, 0, '0); wait_done();

      cfg_write(0, mk(1'b0, 4'd7, 3'd0, 5'd1, 5'd2));
      cfg_write(1, mk(1'b1, 4'd0, 3'd2, 5'd0, 5'd0));
      cfg_write(2, mk(1'b1, 4'd0, 3'd6, 5'd0, 5'd0));
      send(10'h080, 0, 0, '0); wait_done();
      send(10'h000, 0, 0, '0); wait_done();

      cfg_write(0, mk(1'b0, 4'd3, 3'd0, 5'd0, 5'd0));
      send(NF'($urandom), 0, 0, '0); wait_done();
      cfg_write(0, mk(1'b0, 4'd12, 3'd1, 5'd1, 5'd2));
      send(NF'($urandom), 0, 0, '0); wait_done();
      cfg_write(0, mk(1'b0, 4'd0, 3'd0, 5'd30, 5'd30));
      send(NF'($urandom), 0, 0, '0); wait_done();

      load_chain(1'b1);
      send(NF'($urandom), 0, 0, '0); wait_done();
      load_chain(1'b0);
      send(NF'($urandom), 0, 0, '0); wait_done();

      cfg_write(0, mk(1'b1, 4'd0, 3'd3, 5'd0, 5'd0));
      io.out_ready = 1'b0;
      send(NF'($urandom), 0, 0, '0);
      repeat (4) tick();
      cfg_write(0, mk(1'b1, 4'd0, 3'd7, 5'd0, 5'd0));
      repeat (5) tick();
      io.out_ready = 1'b1;
      wait_done();
      send(NF'($urandom), 0, 0, '0); wait_done();

      send(NF'($urandom), 1, 0, mk(1'b1, 4'd0, 3'd1, 5'd0, 5'd0)); wait_done();

      load_chain(1'b1);
      send(NF'($urandom), 0, 0, '0);
      repeat (3) tick();
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("midrst_out_valid", 32'(io.out_valid), 0);
      chk("midrst_in_ready", 32'(io.in_ready), 1);
      chk("midrst_cfg_busy", 32'(cfg_busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      consumed = 0; err_consumed = 0;
      @(posedge clk); #1;
      send(NF'($urandom), 0, 0, '0); wait_done();

      bp = 1'b1;
      for (int it = 0; it < 48; it++) begin
         if (it % 8 == 0) begin
            for (int i = 0; i < MN; i++) begin
               bit leaf = ($urandom_range(0, 2) == 0);
               logic [3:0] fi = leaf ? 4'($urandom_range(0, NF - 1)) : 4'($urandom_range(0, 11));
               cfg_write(i, mk(leaf, fi, CW'($urandom), AW'($urandom_range(0, 25)),
                               AW'($urandom_range(0, 25))));
            end
         end
         if ($urandom_range(0, 3) == 0)
            send(NF'($urandom), 1, $urandom_range(0, MN - 1),
                 mk(1'($urandom), 4'($urandom_range(0, NF - 1)), CW'($urandom),
                    AW'($urandom_range(0, 25)), AW'($urandom_range(0, 25))));
         else
            send(NF'($urandom), 0, 0, '0);
         wait_done();
      end
      bp = 1'b0;
      io.out_ready = 1'b1;
      repeat (2) tick();

`ifdef DT_WALK_STATS_EN
      chk("stat_cnt", 32'(stat_cnt), consumed);
      chk("stat_err", 32'(stat_err), err_consumed);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dt_tree_walker.md
DT_TREE_WALKER -- requirements
Module: dt_tree_walker

Interface
REQ-001 SHALL have parameter N_FEAT, default 10, number of binary input features.
REQ-002 SHALL have parameter CLASS_W, default 3, class code width.
REQ-003 SHALL have parameter MAX_NODES, default 32, node table entries; AW = clog2(MAX_NODES).
REQ-004 SHALL have parameter MAX_DEPTH, default 8, traversal step limit.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature vector offered.
- in_ready  out  1  walker idle; vector accepted when both high.
- in_feat  in  N_FEAT  feature bits.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_class  out  CLASS_W  leaf class.
- out_err  out  1  walk aborted.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  AW  node index.
- cfg_data  in  NODE_W  packed node entry.
- cfg_busy  out  1  high while not IDLE; writes dropped.

Function
REQ-006 Node entry: {is_leaf, feat_idx[clog2(N_FEAT)], cls[CLASS_W], left[AW], right[AW]}; NODE_W is their sum.
REQ-007 Table SHALL be MAX_NODES registers, written on cfg_we when cfg_busy low; not reset.
REQ-008 FSM states IDLE, WALK, DONE; in_ready = (state==IDLE); cfg_busy = !in_ready.
REQ-009 IDLE: on in_valid&in_ready, latch in_feat, ptr<=0, depth<=0, go WALK.
REQ-010 WALK, one node per cycle: leaf -> out_class<=cls, out_err<=0, go DONE.
REQ-011 WALK non-leaf: ptr <= feat[feat_idx] ? right : left; depth<=depth+1.
REQ-012 WALK error, go DONE with out_err=1, out_class=0, when any: feat_idx>=N_FEAT; selected child>=MAX_NODES; non-leaf with depth==MAX_DEPTH-1.
REQ-013 Latency: leaf at depth d -> out_valid high d+1 cycles after the accept edge; error at step s -> s+1 cycles.
REQ-014 DONE: out_valid=1, out_class/out_err stable until out_valid&out_ready, then IDLE; in_ready rises the following cycle.
REQ-015 cfg_we coincident with acceptance SHALL take effect; that walk uses the new entry.
REQ-016 in_feat changes after acceptance SHALL NOT affect the active walk.

Reset
REQ-017 rst_n low: state=IDLE, in_ready=1, out_valid=0, out_class=0, out_err=0, ptr=0, depth=0, cfg_busy=0.
REQ-018 Reset mid-walk SHALL abort with no output; table contents retained.

Configuration
REQ-019 Macro DT_WALK_STATS_EN defined: adds outputs stat_cnt[16] (results consumed) and stat_err[16] (error results consumed), reset 0, saturating at 16'hFFFF.
REQ-020 Macro undefined: stat ports and counters absent; all else identical.

Structure
REQ-021 Package dt_pkg holds state enum, node-entry field offset/width functions, NODE_W function.
REQ-022 Single sub-module dt_node_table (register array, write port, async read by ptr) is natural; FSM in top.

Verification
REQ-023 Root leaf cls=5 at node 0; send any vector -> out_valid 1 cycle after accept, out_class=5, out_err=0.
REQ-024 Node0 feat 7 L=1 R=2; node1 leaf 2; node2 leaf 6; in_feat=10'h080 -> class 6, in_feat=0 -> class 2, latency 2.
REQ-025 Node0 non-leaf L=R=0 (self-loop) -> out_err=1, out_class=0 exactly MAX_DEPTH cycles after accept.
REQ-026 Hold out_ready=0 for 10 cycles -> out_valid/out_class stable, in_ready=0, cfg_we writes ignored (read-back unchanged).
REQ-027 Assert rst_n low mid-walk -> out_valid=0, in_ready=1 next cycle; next vector classifies correctly.
REQ-028 With DT_WALK_STATS_EN: 3 good + 1 error result consumed -> stat_cnt=4, stat_err=1.
